// File: rtl/ysyx_22050518_div_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22050518_div_ctrl
// Sits between the EXU and the iterative divider core (ysyx_22050518_div).
// It decodes RV64M DIV/DIVU/REM/REMU and their W forms, then prepares the
// operands. Divide-by-zero and signed overflow are resolved locally, without
// launching the core. A quotient/remainder pair with the same operands is
// served from the last core result. The final rd value is held under a
// valid/ready handshake.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   flush                  kill any in-flight op (redirect)
//   req_valid/req_ready    request handshake from the EXU
//   req_op                 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_w                  32-bit (W) variant
//   req_src1/req_src2      dividend / divisor
//   res_valid/res_ready    result handshake towards the consumer
//   res_data               final rd value
//   core_valid/core_ready  launch handshake with the divider core
//   core_w/core_signed     core operation mode
//   core_a/core_b          core operands
//   core_flush             one-cycle abort pulse to the core
//   core_done              core completion pulse
//   core_q/core_r          core quotient / remainder
// ---------------------------------------------------------------------------
module ysyx_22050518_div_ctrl #(
  parameter bit REUSE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_w,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic        core_valid,
  input  logic        core_ready,
  output logic        core_w,
  output logic        core_signed,
  output logic [63:0] core_a,
  output logic [63:0] core_b,
  output logic        core_flush,
  input  logic        core_done,
  input  logic [63:0] core_q,
  input  logic [63:0] core_r
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t state, state_next;

  logic        accept;
  logic        prep_signed;
  logic [63:0] prep_a, prep_b;
  logic        b_zero, overflow, special;
  logic [63:0] sp_q, sp_r;
  logic        reuse_hit;

  logic        rem_q;
  logic        w_q;
  logic        signed_q;
  logic [63:0] a_q, b_q;

  logic        ent_valid;
  logic        ent_w, ent_signed;
  logic [63:0] ent_a, ent_b, ent_q, ent_r;

  // Select quotient or remainder. W results are always sign-extended from
  // bit 31, including the unsigned W forms.
  function automatic logic [63:0] pick_result(input logic [63:0] q,
                                              input logic [63:0] r,
                                              input logic        rem,
                                              input logic        w);
    logic [63:0] x;
    x = rem ? r : q;
    return w ? {{32{x[31]}}, x[31:0]} : x;
  endfunction

  assign req_ready   = (state == S_IDLE) && !flush;
  assign accept      = req_valid && req_ready;
  assign res_valid   = (state == S_DONE);
  assign core_valid  = (state == S_ISSUE);
  assign prep_signed = !req_op[0];

  assign core_a      = a_q;
  assign core_b      = b_q;
  assign core_w      = w_q;
  assign core_signed = signed_q;

  // W operands are narrowed to 32 bits, then extended by signedness.
  always_comb begin
    prep_a = req_src1;
    prep_b = req_src2;
    if (req_w) begin
      if (prep_signed) begin
        prep_a = {{32{req_src1[31]}}, req_src1[31:0]};
        prep_b = {{32{req_src2[31]}}, req_src2[31:0]};
      end else begin
        prep_a = {32'h0, req_src1[31:0]};
        prep_b = {32'h0, req_src2[31:0]};
      end
    end
  end

  // Special cases are judged on the effective width only. Divide-by-zero
  // wins over overflow.
  always_comb begin
    b_zero   = req_w ? (prep_b[31:0] == 32'h0) : (prep_b == 64'h0);
    overflow = prep_signed &&
               (req_w ? (prep_a[31:0] == 32'h8000_0000 && prep_b[31:0] == 32'hFFFF_FFFF)
                      : (prep_a == 64'h8000_0000_0000_0000 && prep_b == '1));
    special  = b_zero || overflow;
    sp_q     = b_zero ? '1 : prep_a;
    sp_r     = b_zero ? prep_a : 64'h0;
  end

  // Special cases never consult the reuse entry.
  assign reuse_hit = REUSE_EN && ent_valid && !special &&
                     (ent_a == prep_a) && (ent_b == prep_b) &&
                     (ent_w == req_w) && (ent_signed == prep_signed);

  // Next-state logic. Flush overrides everything and returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = (special || reuse_hit) ? S_DONE : S_ISSUE;
      S_ISSUE: if (core_ready) state_next = S_WAIT;
      S_WAIT:  if (core_done) state_next = S_DONE;
      S_DONE:  if (res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // The core only needs an abort when it actually holds an operation.
  always_ff @(posedge clk) begin
    if (!rst_n) core_flush <= 1'b0;
    else        core_flush <= flush && (state == S_ISSUE || state == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q    <= 1'b0;
      w_q      <= 1'b0;
      signed_q <= 1'b0;
      a_q      <= 64'h0;
      b_q      <= 64'h0;
    end else if (accept) begin
      rem_q    <= req_op[1];
      w_q      <= req_w;
      signed_q <= prep_signed;
      a_q      <= prep_a;
      b_q      <= prep_b;
    end
  end

  // A core_done coinciding with flush is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data <= 64'h0;
    end else if (!flush) begin
      if (accept && special)
        res_data <= pick_result(sp_q, sp_r, req_op[1], req_w);
      else if (accept && reuse_hit)
        res_data <= pick_result(ent_q, ent_r, req_op[1], req_w);
      else if (state == S_WAIT && core_done)
        res_data <= pick_result(core_q, core_r, rem_q, w_q);
    end
  end

  // Raw core outputs are stored so that either half of the pair can be
  // reproduced later.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ent_valid  <= 1'b0;
      ent_w      <= 1'b0;
      ent_signed <= 1'b0;
      ent_a      <= 64'h0;
      ent_b      <= 64'h0;
      ent_q      <= 64'h0;
      ent_r      <= 64'h0;
    end else if (state == S_WAIT && core_done) begin
      ent_valid  <= 1'b1;
      ent_w      <= w_q;
      ent_signed <= signed_q;
      ent_a      <= a_q;
      ent_b      <= b_q;
      ent_q      <= core_q;
      ent_r      <= core_r;
    end
  end

endmodule

// File: tb/tb_ysyx_22050518_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050518_div_ctrl
// Bench for the divider sequencer. A behavioural divider core responds to
// launches. It raises done so that a core-path result appears in cycle 66
// after the accept edge.
// ---------------------------------------------------------------------------
module tb_ysyx_22050518_div_ctrl;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [1:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
    int          launches;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_w;
  logic [63:0] req_src1, req_src2;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        core_valid;
  logic        core_ready;
  logic        core_w;
  logic        core_signed;
  logic [63:0] core_a, core_b;
  logic        core_flush;
  logic        core_done;
  logic [63:0] core_q, core_r;

  int checks = 0;
  int passed = 0;
  int valid_cycles = 0;
  int flush_cycles = 0;
  int rv_cycles = 0;
  logic [63:0] sb[$];
  vec_t vecs[17];

  ysyx_22050518_div_ctrl #(.REUSE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_w(req_w),
    .req_src1(req_src1), .req_src2(req_src2),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .core_valid(core_valid), .core_ready(core_ready), .core_w(core_w),
    .core_signed(core_signed), .core_a(core_a), .core_b(core_b),
    .core_flush(core_flush), .core_done(core_done), .core_q(core_q), .core_r(core_r)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (core_valid) valid_cycles++;
    if (core_flush) flush_cycles++;
    if (res_valid)  rv_cycles++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    checks++;
    if (actual === required) passed++;
    else $display("[TB] FAIL %s: got %h, want %h", name, actual, required);
  endtask

  // Behavioural divider core: full-width or 32-bit, signed or unsigned.
  function automatic void core_model(input logic [63:0] a, input logic [63:0] b,
                                     input logic w, input logic s,
                                     output logic [63:0] q, output logic [63:0] r);
    logic [31:0] a32, b32, q32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'h0) begin
        q32 = '1; r32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == '1) begin
        q32 = a32; r32 = 32'h0;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'h0) begin
        q = '1; r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 64'h0;
      end else if (s) begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end else begin
        q = a / b; r = a % b;
      end
    end
  endfunction

  initial begin
    logic [63:0] mq, mr;
    logic aborted;
    core_done = 1'b0;
    core_q = 64'h0;
    core_r = 64'h0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && core_valid && core_ready) begin
        core_model(core_a, core_b, core_w, core_signed, mq, mr);
        aborted = 1'b0;
        for (int i = 0; i < 64; i++) begin
          @(posedge clk); #1;
          if (core_flush || !rst_n) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          core_done = 1'b1; core_q = mq; core_r = mr;
          @(posedge clk); #1;
          core_done = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input vec_t v, input string tag);
    int base_launch;
    int cycles;
    logic [63:0] exp;
    @(negedge clk);
    req_op = v.op; req_w = v.w; req_src1 = v.a; req_src2 = v.b; req_valid = 1'b1;
    checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    base_launch = valid_cycles;
    @(posedge clk);
    sb.push_back(v.exp);
    #1 req_valid = 1'b0;
    cycles = 1;
    while (!res_valid && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, 64'(cycles), 64'(v.lat));
    @(negedge clk);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
    checkOutput({tag, "_data"}, res_data, exp);
    checkOutput({tag, "_launches"}, 64'(valid_cycles - base_launch), 64'(v.launches));
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    checkOutput({tag, "_res_valid_drop"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bf, bv, br;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_w = 1'b0;
    req_src1 = 64'h0; req_src2 = 64'h0; res_ready = 1'b0; core_ready = 1'b1;

    vecs[0]  = '{OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1};
    vecs[1]  = '{OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 1, 0};
    vecs[2]  = '{OP_DIVU, 1'b0, 64'd5, 64'd0, ONES, 1, 0};
    vecs[3]  = '{OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0};
    vecs[4]  = '{OP_DIV,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0};
    vecs[5]  = '{OP_REM,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 1, 0};
    vecs[6]  = '{OP_DIVU, 1'b1, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1};
    vecs[7]  = '{OP_DIV,  1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1, 0};
    vecs[8]  = '{OP_REM,  1'b0, 64'h8000_0000_0000_0000, ONES, 64'h0, 1, 0};
    vecs[9]  = '{OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, 1};
    vecs[10] = '{OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 1, 0};
    vecs[11] = '{OP_REM,  1'b0, 64'd100, 64'd7, 64'd2, 66, 1};
    vecs[12] = '{OP_DIV,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1};
    vecs[13] = '{OP_REM,  1'b1, 64'd9, 64'h1_0000_0000, 64'd9, 1, 0};
    vecs[14] = '{OP_DIV,  1'b0, 64'h5_0000_0000, 64'h1_0000_0000, 64'd5, 66, 1};
    vecs[15] = '{OP_DIVU, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 66, 1};
    vecs[16] = '{OP_REMU, 1'b1, 64'hFFFF_FFFF, 64'd0, ONES, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_res_valid", 64'(res_valid), 64'd0);
    checkOutput("reset_res_data", res_data, 64'h0);
    checkOutput("reset_core_valid", 64'(core_valid), 64'd0);
    checkOutput("reset_core_flush", 64'(core_flush), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 17; i++) applyStimulus(vecs[i], $sformatf("v%0d", i));

    // Flush in cycle 30 of a core op; the entry primed here must be forgotten.
    applyStimulus('{OP_DIV, 1'b0, 64'd50, 64'd7, 64'd7, 66, 1}, "fl_prime");
    @(negedge clk);
    req_op = OP_DIV; req_w = 1'b0; req_src1 = 64'd60; req_src2 = 64'd7; req_valid = 1'b1;
    bv = valid_cycles; bf = flush_cycles; br = rv_cycles;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = OP_REM; req_src1 = 64'd50; req_src2 = 64'd7;
    checkOutput("fl_req_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    checkOutput("fl_core_flush", 64'(core_flush), 64'd1);
    repeat (80) @(posedge clk);
    #1;
    checkOutput("fl_flush_pulse", 64'(flush_cycles - bf), 64'd1);
    checkOutput("fl_no_result", 64'(rv_cycles - br), 64'd0);
    checkOutput("fl_launches", 64'(valid_cycles - bv), 64'd1);
    applyStimulus('{OP_REM, 1'b0, 64'd50, 64'd7, 64'd1, 66, 1}, "fl_rem_miss");

    // Flush landing on the core_done cycle: the result must be dropped.
    @(negedge clk);
    req_op = OP_DIV; req_w = 1'b0; req_src1 = 64'd80; req_src2 = 64'd9; req_valid = 1'b1;
    bf = flush_cycles; br = rv_cycles;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (64) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("fd_core_flush", 64'(core_flush), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("fd_flush_pulse", 64'(flush_cycles - bf), 64'd1);
    checkOutput("fd_no_result", 64'(rv_cycles - br), 64'd0);
    checkOutput("fd_res_data_kept", res_data, 64'd1);
    applyStimulus('{OP_REM, 1'b0, 64'd80, 64'd9, 64'd8, 66, 1}, "fd_rem_miss");

    // Backpressure: hold the result with res_ready low and a pending request.
    @(negedge clk);
    req_op = OP_DIVU; req_w = 1'b0; req_src1 = 64'd5; req_src2 = 64'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_op = OP_REMU;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d_res_valid", i), 64'(res_valid), 64'd1);
      checkOutput($sformatf("bp%0d_res_data", i), res_data, ONES);
      checkOutput($sformatf("bp%0d_req_ready", i), 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_exit_res_valid", 64'(res_valid), 64'd0);
    checkOutput("bp_exit_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b0; res_ready = 1'b0;

    // Reset in the middle of a core op: no core_flush, state cleared.
    @(negedge clk);
    req_op = OP_DIVU; req_w = 1'b0; req_src1 = 64'd100; req_src2 = 64'd3; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bf = flush_cycles;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mid_res_valid", 64'(res_valid), 64'd0);
    checkOutput("rst_mid_core_valid", 64'(core_valid), 64'd0);
    checkOutput("rst_mid_res_data", res_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_mid_no_core_flush", 64'(flush_cycles - bf), 64'd0);
    applyStimulus('{OP_REMU, 1'b0, 64'd100, 64'd3, 64'd1, 66, 1}, "rst_after");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
